// File: rtl/rf_requester.sv
// Register-file command initiator: arbitrates write-back and decode requests,
// issues one RF command per accepted request and returns read operands to decode.
`timescale 1ns/1ps
`ifndef RF_NOP
`define RF_NOP   2'b00
`endif
`ifndef RF_READ
`define RF_READ  2'b01
`endif
`ifndef RF_WRITE
`define RF_WRITE 2'b10
`endif

module rf_requester #(
  parameter int LEN   = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy_in,
  input  logic             rd_req_valid,
  input  logic [4:0]       rd_rs1,
  input  logic [4:0]       rd_rs2,
  output logic             rd_req_ready,
  output logic             rd_resp_valid,
  output logic [LEN-1:0]   rd_rs1_data,
  output logic [LEN-1:0]   rd_rs2_data,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic [LEN-1:0]   wb_data,
  output logic             wb_ready,
  output logic [1:0]       rf_signal,
  output logic [4:0]       rf_rs1,
  output logic [4:0]       rf_rs2,
  output logic [4:0]       rf_rd,
  output logic [LEN-1:0]   rf_data,
  input  logic [LEN-1:0]   rf_rs1_data,
  input  logic [LEN-1:0]   rf_rs2_data,
  output logic [CNT_W-1:0] read_count,
  output logic [CNT_W-1:0] write_count
);

  typedef enum logic [1:0] {IDLE, ISSUE_W, ISSUE_R, CAPTURE} state_t;

  state_t           state_q;
  logic [1:0]       rf_signal_q;
  logic [4:0]       rf_rs1_q, rf_rs2_q, rf_rd_q;
  logic [LEN-1:0]   rf_data_q;
  logic [LEN-1:0]   rd_rs1_data_q, rd_rs2_data_q;
  logic             rd_resp_valid_q;
  logic [CNT_W-1:0] read_count_q, write_count_q;
  logic [CNT_W-1:0] read_count_d, write_count_d;
  logic             wr_acc, rd_acc;

  // Writes win arbitration so a read issued afterwards observes the new value.
  assign wb_ready      = rdy_in && (state_q == IDLE);
  assign rd_req_ready  = wb_ready && !wb_valid;
  assign wr_acc        = wb_ready && wb_valid;
  assign rd_acc        = rd_req_ready && rd_req_valid;
  assign read_count_d  = read_count_q + CNT_W'(1);
  assign write_count_d = write_count_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      rf_signal_q     <= `RF_NOP;
      rf_rs1_q        <= '0;
      rf_rs2_q        <= '0;
      rf_rd_q         <= '0;
      rf_data_q       <= '0;
      rd_rs1_data_q   <= '0;
      rd_rs2_data_q   <= '0;
      rd_resp_valid_q <= 1'b0;
      read_count_q    <= '0;
      write_count_q   <= '0;
    end else if (rdy_in) begin
      rd_resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_acc) begin
            // Writes to x0 are swallowed here and never reach the register file.
            if (wb_rd != 5'd0) begin
              rf_rd_q     <= wb_rd;
              rf_data_q   <= wb_data;
              rf_signal_q <= `RF_WRITE;
              state_q     <= ISSUE_W;
            end
          end else if (rd_acc) begin
            rf_rs1_q    <= rd_rs1;
            rf_rs2_q    <= rd_rs2;
            rf_signal_q <= `RF_READ;
            state_q     <= ISSUE_R;
          end
        end
        ISSUE_W: begin
          rf_signal_q   <= `RF_NOP;
          write_count_q <= write_count_d;
          state_q       <= IDLE;
        end
        ISSUE_R: begin
          rf_signal_q <= `RF_NOP;
          state_q     <= CAPTURE;
        end
        CAPTURE: begin
          rd_rs1_data_q   <= (rf_rs1_q == 5'd0) ? '0 : rf_rs1_data;
          rd_rs2_data_q   <= (rf_rs2_q == 5'd0) ? '0 : rf_rs2_data;
          rd_resp_valid_q <= 1'b1;
          read_count_q    <= read_count_d;
          state_q         <= IDLE;
        end
        default: begin
          rf_signal_q <= `RF_NOP;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rf_signal     = rf_signal_q;
  assign rf_rs1        = rf_rs1_q;
  assign rf_rs2        = rf_rs2_q;
  assign rf_rd         = rf_rd_q;
  assign rf_data       = rf_data_q;
  assign rd_rs1_data   = rd_rs1_data_q;
  assign rd_rs2_data   = rd_rs2_data_q;
  assign rd_resp_valid = rd_resp_valid_q;
  assign read_count    = read_count_q;
  assign write_count   = write_count_q;

endmodule

// File: tb/tb_rf_requester.sv
// Self-checking bench for rf_requester: directed scenarios plus a randomized run
// scored against an architectural register model and a behavioural register file.
`timescale 1ns/1ps
`ifndef RF_NOP
`define RF_NOP   2'b00
`endif
`ifndef RF_READ
`define RF_READ  2'b01
`endif
`ifndef RF_WRITE
`define RF_WRITE 2'b10
`endif

module tb_rf_requester;
  localparam int LEN = 32;
  localparam int CW  = 4;
  localparam int OW  = 2 + 15 + LEN + 2 * LEN + 1 + 2 * CW;

  logic           clk, rst, rdy_in;
  logic           rd_req_valid, rd_req_ready, rd_resp_valid;
  logic [4:0]     rd_rs1, rd_rs2;
  logic [LEN-1:0] rd_rs1_data, rd_rs2_data;
  logic           wb_valid, wb_ready;
  logic [4:0]     wb_rd;
  logic [LEN-1:0] wb_data;
  logic [1:0]     rf_signal;
  logic [4:0]     rf_rs1, rf_rs2, rf_rd;
  logic [LEN-1:0] rf_data, rf_rs1_data, rf_rs2_data;
  logic [CW-1:0]  read_count, write_count;
  logic [OW-1:0]  all_outs;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [LEN-1:0]   mem  [32];
  logic [LEN-1:0]   arch [32];
  logic [2*LEN-1:0] rq[$];
  logic [LEN+4:0]   wq[$];
  logic [2*LEN-1:0] exp_r;
  logic [LEN+4:0]   exp_w;
  logic [CW-1:0]    exp_rc = '0;
  logic [CW-1:0]    exp_wc = '0;

  rf_requester #(.LEN(LEN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .rd_req_valid(rd_req_valid), .rd_rs1(rd_rs1), .rd_rs2(rd_rs2),
    .rd_req_ready(rd_req_ready), .rd_resp_valid(rd_resp_valid),
    .rd_rs1_data(rd_rs1_data), .rd_rs2_data(rd_rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .rf_signal(rf_signal), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
    .rf_data(rf_data), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .read_count(read_count), .write_count(write_count)
  );

  assign all_outs = {rf_signal, rf_rs1, rf_rs2, rf_rd, rf_data, rd_rs1_data,
                     rd_rs2_data, rd_resp_valid, read_count, write_count};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: consumes a command on the edge it is presented with rdy_in high.
  always @(posedge clk) begin
    if (rdy_in) begin
      if (rf_signal == `RF_WRITE) mem[rf_rd] <= rf_data;
      if (rf_signal == `RF_READ) begin
        rf_rs1_data <= mem[rf_rs1];
        rf_rs2_data <= mem[rf_rs2];
      end
    end
  end

  // Scoreboard: requests accepted in program order against an architectural x-file.
  always @(negedge clk) begin
    if (rst) begin
      rq.delete();
      wq.delete();
      exp_rc = '0;
      exp_wc = '0;
    end else begin
      if (rdy_in && rf_signal == `RF_WRITE) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL rf_write_unexpected: rd=%0d data=%h, required no write", rf_rd, rf_data);
        end else begin
          exp_w = wq.pop_front();
          if ({rf_rd, rf_data} !== exp_w) begin
            errors++;
            $display("FAIL rf_write_cmd: got %h, required %h", {rf_rd, rf_data}, exp_w);
          end
        end
      end
      if (rdy_in && rd_resp_valid) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL rd_resp_unexpected: data=%h, required no response", {rd_rs1_data, rd_rs2_data});
        end else begin
          exp_r = rq.pop_front();
          if ({rd_rs1_data, rd_rs2_data} !== exp_r) begin
            errors++;
            $display("FAIL rd_resp_data: got %h, required %h", {rd_rs1_data, rd_rs2_data}, exp_r);
          end
        end
      end
      if (wb_valid && wb_ready && wb_rd != 5'd0) begin
        arch[wb_rd] = wb_data;
        wq.push_back({wb_rd, wb_data});
        exp_wc++;
      end
      if (rd_req_valid && rd_req_ready) begin
        rq.push_back({arch[rd_rs1], arch[rd_rs2]});
        exp_rc++;
      end
    end
  end

  task automatic wr(input logic [4:0] a, input logic [LEN-1:0] d);
    int n = 0;
    wb_valid = 1'b1; wb_rd = a; wb_data = d;
    do begin @(negedge clk); n++; end while (!wb_ready && n < 40);
    if (!wb_ready) begin
      checks++; errors++;
      $display("FAIL wr_accept_timeout: wb_ready=%b, required 1", wb_ready);
    end
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b, output int acc);
    int n = 0;
    rd_req_valid = 1'b1; rd_rs1 = a; rd_rs2 = b;
    do begin @(negedge clk); n++; end while (!rd_req_ready && n < 40);
    if (!rd_req_ready) begin
      checks++; errors++;
      $display("FAIL rd_accept_timeout: rd_req_ready=%b, required 1", rd_req_ready);
    end
    @(posedge clk); #1;
    rd_req_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_resp(output int t);
    int n = 0;
    do begin @(negedge clk); n++; end while (!rd_resp_valid && n < 20);
    t = cyc;
    if (!rd_resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout: rd_resp_valid=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy_in = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    rd_req_valid = 1'b0; rd_rs1 = '0; rd_rs2 = '0;
    @(negedge clk);
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h, required 0", all_outs);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL idle_outputs: got %h, required 0", all_outs);
    end
    checks++;
    if ({wb_ready, rd_req_ready} !== 2'b11) begin
      errors++; $display("FAIL idle_readies: got %b, required 11", {wb_ready, rd_req_ready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int acc, t;
    wr(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if ({rf_signal, rf_rd, rf_data} !== {`RF_WRITE, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL write_cmd: got %h, required %h", {rf_signal, rf_rd, rf_data}, {`RF_WRITE, 5'd5, 32'hDEADBEEF});
    end
    @(negedge clk);
    checks++;
    if (rf_signal !== `RF_NOP) begin
      errors++; $display("FAIL write_one_cycle: rf_signal=%b, required %b", rf_signal, `RF_NOP);
    end
    @(posedge clk); #1;
    rd(5'd5, 5'd0, acc);
    wait_resp(t);
    // Accept edge, index edge, capture edge: valid is seen two edges after accept.
    checks++;
    if (t - acc != 2) begin
      errors++; $display("FAIL read_latency: %0d edges after accept, required 2", t - acc);
    end
    checks++;
    if ({rd_rs1_data, rd_rs2_data} !== {32'hDEADBEEF, 32'h0}) begin
      errors++; $display("FAIL read_x5_x0: got %h, required deadbeef00000000", {rd_rs1_data, rd_rs2_data});
    end
    checks++;
    if ({write_count, read_count} !== {4'd1, 4'd1}) begin
      errors++; $display("FAIL counts_1_1: got wc=%0d rc=%0d, required 1 1", write_count, read_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_simultaneous();
    int wacc, racc, t, n;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
    rd_req_valid = 1'b1; rd_rs1 = 5'd3; rd_rs2 = 5'd0;
    @(negedge clk);
    checks++;
    if ({wb_ready, rd_req_ready} !== 2'b10) begin
      errors++; $display("FAIL simul_readies: got %b, required 10", {wb_ready, rd_req_ready});
    end
    @(posedge clk); #1;
    wacc = cyc;
    wb_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({rf_signal, rf_rd} !== {`RF_WRITE, 5'd3}) begin
      errors++; $display("FAIL simul_write_first: got %h, required %h", {rf_signal, rf_rd}, {`RF_WRITE, 5'd3});
    end
    n = 0;
    while (!rd_req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    rd_req_valid = 1'b0;
    racc = cyc;
    checks++;
    if (racc - wacc != 2) begin
      errors++; $display("FAIL simul_read_accept: %0d edges after write, required 2", racc - wacc);
    end
    wait_resp(t);
    checks++;
    if ({rd_rs1_data, rd_rs2_data} !== {32'h11, 32'h0}) begin
      errors++; $display("FAIL simul_read_data: got %h, required 0000001100000000", {rd_rs1_data, rd_rs2_data});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_x0_write();
    int acc, t;
    logic seen = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if (wb_ready !== 1'b1) begin
      errors++; $display("FAIL x0_wb_ready: got %b, required 1", wb_ready);
    end
    @(posedge clk); #1;
    wb_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_req_ready !== 1'b1) begin
      errors++; $display("FAIL x0_stays_idle: rd_req_ready=%b, required 1", rd_req_ready);
    end
    repeat (3) begin
      if (rf_signal === `RF_WRITE) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL x0_no_write: RF_WRITE seen=1, required 0");
    end
    checks++;
    if (write_count !== 4'd2) begin
      errors++; $display("FAIL x0_write_count: got %0d, required 2", write_count);
    end
    @(posedge clk); #1;
    rd(5'd0, 5'd5, acc);
    wait_resp(t);
    checks++;
    if ({rd_rs1_data, rd_rs2_data} !== {32'h0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL x0_read: got %h, required 00000000deadbeef", {rd_rs1_data, rd_rs2_data});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_freeze();
    int acc, r, t;
    rd(5'd5, 5'd3, acc);
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({rf_signal, rf_rs1, rf_rs2} !== {`RF_READ, 5'd5, 5'd3}) begin
        errors++; $display("FAIL freeze_hold_%0d: got %h, required %h", i, {rf_signal, rf_rs1, rf_rs2}, {`RF_READ, 5'd5, 5'd3});
      end
    end
    @(posedge clk); #1;
    rdy_in = 1'b1;
    r = cyc;
    wait_resp(t);
    checks++;
    if (t - r != 2) begin
      errors++; $display("FAIL freeze_latency: %0d edges after release, required 2", t - r);
    end
    checks++;
    if ({rd_rs1_data, rd_rs2_data} !== {32'hDEADBEEF, 32'h11}) begin
      errors++; $display("FAIL freeze_data: got %h, required deadbeef00000011", {rd_rs1_data, rd_rs2_data});
    end
    @(posedge clk); #1;
    rdy_in = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h12345678;
    rd_req_valid = 1'b1; rd_rs1 = 5'd7; rd_rs2 = 5'd7;
    repeat (2) @(negedge clk);
    checks++;
    if ({wb_ready, rd_req_ready} !== 2'b00) begin
      errors++; $display("FAIL freeze_readies: got %b, required 00", {wb_ready, rd_req_ready});
    end
    @(posedge clk); #1;
    wb_valid = 1'b0; rd_req_valid = 1'b0; rdy_in = 1'b1;
  endtask

  task automatic test_reset_capture();
    int acc, t;
    logic seen = 1'b0;
    rd(5'd3, 5'd5, acc);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL async_reset: got %h, required 0", all_outs);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rd_resp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL reset_no_resp: pulse seen=1, required 0");
    end
    @(posedge clk); #1;
    rd(5'd3, 5'd0, acc);
    wait_resp(t);
    checks++;
    if ({rd_rs1_data, rd_rs2_data, read_count, write_count} !== {32'h11, 32'h0, 4'd1, 4'd0}) begin
      errors++; $display("FAIL post_reset_read: got %h, required %h", {rd_rs1_data, rd_rs2_data, read_count, write_count}, {32'h11, 32'h0, 4'd1, 4'd0});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic wacc, racc;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      wacc = wb_valid && wb_ready;
      racc = rd_req_valid && rd_req_ready;
      @(posedge clk); #1;
      if (wacc) wb_valid = 1'b0;
      if (racc) rd_req_valid = 1'b0;
      if (!wb_valid && $urandom_range(3) == 0) begin
        wb_valid = 1'b1;
        wb_rd    = 5'($urandom_range(31));
        wb_data  = $urandom;
      end
      if (!rd_req_valid && $urandom_range(2) == 0) begin
        rd_req_valid = 1'b1;
        rd_rs1       = 5'($urandom_range(31));
        rd_rs2       = 5'($urandom_range(31));
      end
      rdy_in = ($urandom_range(4) != 0);
    end
    wb_valid = 1'b0; rd_req_valid = 1'b0; rdy_in = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (rq.size() != 0 || wq.size() != 0) begin
      errors++; $display("FAIL random_drain: %0d reads and %0d writes outstanding, required 0 0", rq.size(), wq.size());
    end
    checks++;
    if ({read_count, write_count} !== {exp_rc, exp_wc}) begin
      errors++; $display("FAIL random_counts: got rc=%0d wc=%0d, required rc=%0d wc=%0d", read_count, write_count, exp_rc, exp_wc);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [LEN-1:0] v;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      mem[i]  <= (i == 0) ? 32'hA5A55A5A : v;
      arch[i]  = (i == 0) ? '0 : v;
    end
    test_reset();
    test_write_read();
    test_simultaneous();
    test_x0_write();
    test_freeze();
    test_reset_capture();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at 1ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
